// File: rtl/config_access_pkg.sv
// Shared types and width helpers for the configuration-export serializer.
package config_access_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } ser_state_e;

    // Default geometry, handy for instantiations that keep the stock sizes.
    localparam int DEF_CONFIG_BITS = 8;
    localparam int DEF_DIV_RATIO   = 4;

    // Counter widths carry one spare bit so a value of 1 still gets a legal vector.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/config_ser_tx.sv
// 3-wire serial transmitter: divider, MSB-first shift register, FSM and busy flag.
// Every output is a flop, so input changes never reach the pins combinationally.
module config_ser_tx
    import config_access_pkg::*;
#(
    parameter int NoConfigBits = DEF_CONFIG_BITS,
    parameter int DivRatio     = DEF_DIV_RATIO
) (
    input  logic                    UserCLK,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [NoConfigBits-1:0] data,
    output logic                    busy,
    output logic                    ser_clk,
    output logic                    ser_dat,
    output logic                    ser_latch
);

    localparam int CW = cnt_w(NoConfigBits);
    localparam int DW = cnt_w(DivRatio);
    localparam logic [DW-1:0] DIV_LAST = DW'(DivRatio - 1);
    localparam logic [CW-1:0] IDX_LAST = CW'(NoConfigBits - 1);

    ser_state_e              state, state_nx;
    logic [DW-1:0]           div, div_nx;
    logic [CW-1:0]           idx, idx_nx;
    logic [NoConfigBits-1:0] shreg, shreg_nx;
    logic                    busy_nx, clk_nx, dat_nx, latch_nx;
    logic                    win_end;

    assign win_end = (div == DIV_LAST);

    // State, counters and the registered pin values.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            div       <= '0;
            idx       <= '0;
            shreg     <= '0;
            busy      <= 1'b0;
            ser_clk   <= 1'b0;
            ser_dat   <= 1'b0;
            ser_latch <= 1'b0;
        end else begin
            state     <= state_nx;
            div       <= div_nx;
            idx       <= idx_nx;
            shreg     <= shreg_nx;
            busy      <= busy_nx;
            ser_clk   <= clk_nx;
            ser_dat   <= dat_nx;
            ser_latch <= latch_nx;
        end
    end

    // Next state plus next pin values; each phase lasts DivRatio cycles.
    always_comb begin
        state_nx = state;
        div_nx   = div;
        idx_nx   = idx;
        shreg_nx = shreg;
        busy_nx  = busy;
        clk_nx   = ser_clk;
        dat_nx   = ser_dat;
        latch_nx = ser_latch;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nx = SHIFT_LO;
                    shreg_nx = data;
                    idx_nx   = IDX_LAST;
                    div_nx   = '0;
                    busy_nx  = 1'b1;
                    clk_nx   = 1'b0;
                    dat_nx   = data[NoConfigBits-1];
                    latch_nx = 1'b0;
                end
            end
            SHIFT_LO: begin
                if (win_end) begin
                    state_nx = SHIFT_HI;
                    div_nx   = '0;
                    clk_nx   = 1'b1;
                end else begin
                    div_nx = div + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (win_end) begin
                    div_nx = '0;
                    clk_nx = 1'b0;
                    if (idx != '0) begin
                        state_nx = SHIFT_LO;
                        shreg_nx = shreg << 1;
                        idx_nx   = idx - 1'b1;
                        dat_nx   = shreg_nx[NoConfigBits-1];
                    end else begin
                        state_nx = LATCH;
                        dat_nx   = 1'b0;
                        latch_nx = 1'b1;
                    end
                end else begin
                    div_nx = div + 1'b1;
                end
            end
            LATCH: begin
                if (win_end) begin
                    state_nx = IDLE;
                    div_nx   = '0;
                    latch_nx = 1'b0;
                    busy_nx  = 1'b0;
                end else begin
                    div_nx = div + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/config_access_ser.sv
// Configuration-export BEL: shadows ConfigBits on commit, drives them in parallel
// on C_bit and streams them out over the serial link.
module config_access_ser
    import config_access_pkg::*;
#(
    parameter int NoConfigBits = DEF_CONFIG_BITS,
    parameter int DivRatio     = DEF_DIV_RATIO,
    parameter int AutoCommit   = 0
) (
    input  logic                    UserCLK,
    input  logic                    resetn,
    input  logic                    commit,
    output logic                    busy,
    output logic [NoConfigBits-1:0] C_bit,
    output logic                    SER_CLK,
    output logic                    SER_DAT,
    output logic                    SER_LATCH,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    logic [NoConfigBits-1:0] shadow;
    logic                    pending;
    logic                    differs, trig_req, load;

    // Auto mode treats any divergence from the shadow as a commit request.
    assign differs  = (AutoCommit != 0) && (ConfigBits != shadow);
    assign trig_req = commit | differs;
    assign load     = !busy && (trig_req || pending);

    // Shadow only moves at capture; requests seen while busy coalesce into one.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            shadow  <= '0;
            pending <= 1'b0;
        end else if (load) begin
            shadow  <= ConfigBits;
            pending <= 1'b0;
        end else if (busy && trig_req) begin
            pending <= 1'b1;
        end
    end

    assign C_bit = shadow;

    config_ser_tx #(
        .NoConfigBits(NoConfigBits),
        .DivRatio    (DivRatio)
    ) u_tx (
        .UserCLK  (UserCLK),
        .resetn   (resetn),
        .load     (load),
        .data     (ConfigBits),
        .busy     (busy),
        .ser_clk  (SER_CLK),
        .ser_dat  (SER_DAT),
        .ser_latch(SER_LATCH)
    );

endmodule

// File: tb/tb_config_access_ser.sv
// Bench for config_access_ser: default instance scoreboarded on serial words,
// plus an AutoCommit / 1-bit / DivRatio=1 instance checked cycle by cycle.
module tb_config_access_ser;

    logic       UserCLK = 1'b0;
    logic       resetn;
    logic       commit;
    logic [7:0] cfg0;
    logic [0:0] cfg1;

    logic       busy0, ser_clk0, ser_dat0, ser_latch0;
    logic [7:0] c_bit0;
    logic       busy1, ser_clk1, ser_dat1, ser_latch1;
    logic [0:0] c_bit1;

    int n_chk  = 0;
    int n_fail = 0;
    int n_words = 0;

    logic [8:0] exp_q[$];

    always #5 UserCLK = ~UserCLK;

    config_access_ser #(.NoConfigBits(8), .DivRatio(4), .AutoCommit(0)) dut0 (
        .UserCLK(UserCLK), .resetn(resetn), .commit(commit), .busy(busy0),
        .C_bit(c_bit0), .SER_CLK(ser_clk0), .SER_DAT(ser_dat0),
        .SER_LATCH(ser_latch0), .ConfigBits(cfg0)
    );

    config_access_ser #(.NoConfigBits(1), .DivRatio(1), .AutoCommit(1)) dut1 (
        .UserCLK(UserCLK), .resetn(resetn), .commit(1'b0), .busy(busy1),
        .C_bit(c_bit1), .SER_CLK(ser_clk1), .SER_DAT(ser_dat1),
        .SER_LATCH(ser_latch1), .ConfigBits(cfg1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Serial monitor for dut0: rebuild words on SER_CLK rises, score on SER_LATCH rise.
    logic       prev_clk = 1'b0, prev_dat = 1'b0, prev_latch = 1'b0;
    logic [7:0] sh = '0;
    int         bit_cnt = 0, latch_len = 0, busy_len = 0;
    logic [8:0] exp_w;
    always @(negedge UserCLK) begin
        if (!resetn) begin
            sh = '0; bit_cnt = 0; latch_len = 0; busy_len = 0;
        end else begin
            if (ser_clk0 && prev_clk) chk("dat_stable", ser_dat0, prev_dat);
            if (ser_clk0 && !prev_clk) begin
                sh = {sh[6:0], ser_dat0};
                bit_cnt++;
            end
            if (ser_latch0 && !prev_latch) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                chk("ser_word", {1'b0, sh}, exp_w);
                chk("ser_bits", bit_cnt, 8);
                n_words++;
                bit_cnt = 0;
            end
            if (ser_latch0) latch_len++;
            else if (latch_len != 0) begin
                chk("latch_len", latch_len, 4);
                latch_len = 0;
            end
            if (busy0) busy_len++;
            else if (busy_len != 0) begin
                chk("busy_len", busy_len, 68);
                busy_len = 0;
            end
        end
        prev_clk   = ser_clk0;
        prev_dat   = ser_dat0;
        prev_latch = ser_latch0;
    end

    // Expected {busy,SER_CLK,SER_DAT,SER_LATCH} for the 1-bit auto transfer of a 1.
    logic [3:0] auto_tbl[4];
    int n;

    initial begin
        auto_tbl[0] = 4'b1010;
        auto_tbl[1] = 4'b1110;
        auto_tbl[2] = 4'b1001;
        auto_tbl[3] = 4'b0000;
        resetn = 1'b0; commit = 1'b0; cfg0 = '0; cfg1 = '0;
        repeat (3) @(negedge UserCLK);
        chk("rst_out0", {busy0, ser_clk0, ser_dat0, ser_latch0, c_bit0}, 0);
        chk("rst_out1", {busy1, ser_clk1, ser_dat1, ser_latch1, c_bit1}, 0);
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge UserCLK);
            chk("idle0", {busy0, ser_clk0, ser_dat0, ser_latch0, c_bit0}, 0);
            chk("idle1", {busy1, ser_clk1, ser_dat1, ser_latch1, c_bit1}, 0);
        end

        // Single commit of A5, then three coalescing commits of 3C mid-transfer.
        cfg0 = 8'hA5;
        exp_q.push_back(9'h0A5);
        commit = 1'b1;
        @(negedge UserCLK);
        commit = 1'b0;
        chk("cbit_cap", c_bit0, 8'hA5);
        chk("busy_cap", busy0, 1);
        chk("dat_first", ser_dat0, 1);
        repeat (19) @(negedge UserCLK);
        cfg0 = 8'h3C;
        exp_q.push_back(9'h03C);
        for (int i = 0; i < 3; i++) begin
            commit = 1'b1;
            @(negedge UserCLK);
            commit = 1'b0;
            @(negedge UserCLK);
        end
        n = 0;
        while (busy0 && n < 200) begin
            chk("cbit_hold", c_bit0, 8'hA5);
            @(negedge UserCLK);
            n++;
        end
        chk("xfer1_done", busy0, 0);
        @(negedge UserCLK);
        chk("gap_busy", busy0, 1);
        chk("cbit_next", c_bit0, 8'h3C);
        n = 0;
        while (busy0 && n < 200) begin
            @(negedge UserCLK);
            n++;
        end
        chk("xfer2_done", busy0, 0);
        repeat (20) @(negedge UserCLK);
        chk("no_third", busy0, 0);
        chk("q_empty", exp_q.size(), 0);
        chk("n_words", n_words, 2);

        // Auto-commit instance: toggle 0->1, transfer starts on the next edge.
        cfg1 = 1'b1;
        @(negedge UserCLK);
        for (int i = 0; i < 4; i++) begin
            chk("auto_seq", {busy1, ser_clk1, ser_dat1, ser_latch1}, auto_tbl[i]);
            chk("auto_cbit", c_bit1, 1);
            @(negedge UserCLK);
        end
        for (int i = 0; i < 20; i++) begin
            chk("auto_stable", busy1, 0);
            @(negedge UserCLK);
        end
        cfg1 = 1'b0;
        repeat (10) @(negedge UserCLK);

        // Reset 20 cycles into a transfer with a pending request outstanding.
        cfg0 = 8'h5A;
        commit = 1'b1;
        @(negedge UserCLK);
        commit = 1'b0;
        chk("cbit_5a", c_bit0, 8'h5A);
        repeat (9) @(negedge UserCLK);
        commit = 1'b1;
        @(negedge UserCLK);
        commit = 1'b0;
        repeat (9) @(negedge UserCLK);
        chk("busy_pre_rst", busy0, 1);
        resetn = 1'b0;
        #1;
        chk("rst_async0", {busy0, ser_clk0, ser_dat0, ser_latch0, c_bit0}, 0);
        chk("rst_async1", {busy1, ser_clk1, ser_dat1, ser_latch1, c_bit1}, 0);
        repeat (3) @(negedge UserCLK);
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge UserCLK);
            chk("post_rst", {busy0, ser_clk0, ser_dat0, ser_latch0, c_bit0}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
